// File: rtl/exe_pkg.sv
// Purpose: shared constants and types for the execute stage (ALU op codes, shift types, EXE/MEM bundle).
// Ports: none (package). Exports DW/RW, EXE_* op codes, shift_e, exmem_t and the ror32 helper.
// Build option: FWD_EN (see exe_if / exe_stage) adds operand forwarding; nothing here depends on it.
package exe_pkg;

  localparam int DW = 32;
  localparam int RW = 4;

  // ALU operation encoding carried in exe_cmd
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  // Register-operand shift type, shift_operand[6:5]
  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  // EXE/MEM pipeline register contents
  typedef struct packed {
    logic          wb_en;
    logic          mem_r;
    logic          mem_w;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] st_val;
    logic [RW-1:0] dest;
  } exmem_t;

  // Rotate right; doubling the word makes amount 0 a clean pass-through.
  function automatic logic [DW-1:0] ror32(input logic [DW-1:0] x, input logic [4:0] amt);
    logic [2*DW-1:0] d;
    d = {x, x} >> amt;
    return d[DW-1:0];
  endfunction

endpackage

// File: rtl/exe_if.sv
// Purpose: decoded instruction bundle travelling from decode into the execute stage.
// Ports: master = decode side (drives), slave = execute side (samples).
// Build option: FWD_EN adds sel_src1/sel_src2 and the mem/wb forwarding values.
interface exe_if
  import exe_pkg::*;
#(
  parameter int DW = exe_pkg::DW,
  parameter int RW = exe_pkg::RW
);
  logic          wb_en_in;
  logic          mem_r_in;
  logic          mem_w_in;
  logic [3:0]    exe_cmd;
  logic          b_in;
  logic          s_in;
  logic [DW-1:0] pc_in;
  logic [DW-1:0] val_rn;
  logic [DW-1:0] val_rm;
  logic          imm;
  logic [11:0]   shift_operand;
  logic [23:0]   signed_imm;
  logic [RW-1:0] dest_in;
`ifdef FWD_EN
  logic [1:0]    sel_src1;
  logic [1:0]    sel_src2;
  logic [DW-1:0] mem_fwd_val;
  logic [DW-1:0] wb_fwd_val;

  modport master (output wb_en_in, mem_r_in, mem_w_in, exe_cmd, b_in, s_in, pc_in, val_rn,
                  val_rm, imm, shift_operand, signed_imm, dest_in,
                  sel_src1, sel_src2, mem_fwd_val, wb_fwd_val);
  modport slave  (input  wb_en_in, mem_r_in, mem_w_in, exe_cmd, b_in, s_in, pc_in, val_rn,
                  val_rm, imm, shift_operand, signed_imm, dest_in,
                  sel_src1, sel_src2, mem_fwd_val, wb_fwd_val);
`else
  modport master (output wb_en_in, mem_r_in, mem_w_in, exe_cmd, b_in, s_in, pc_in, val_rn,
                  val_rm, imm, shift_operand, signed_imm, dest_in);
  modport slave  (input  wb_en_in, mem_r_in, mem_w_in, exe_cmd, b_in, s_in, pc_in, val_rn,
                  val_rm, imm, shift_operand, signed_imm, dest_in);
`endif
endinterface

// File: rtl/val2_gen.sv
// Purpose: second-operand generator (memory offset, rotated immediate or shifted register); combinational.
// Ports: mem_en_i (load/store), imm_i, so_i (instr[11:0]), rm_i -> val2_o.
// Build option: none.
module val2_gen
  import exe_pkg::*;
(
  input  logic          mem_en_i,
  input  logic          imm_i,
  input  logic [11:0]   so_i,
  input  logic [DW-1:0] rm_i,
  output logic [DW-1:0] val2_o
);
  logic [4:0] sh_amt;
  logic [4:0] rot_amt;

  assign sh_amt  = so_i[11:7];
  assign rot_amt = {so_i[11:8], 1'b0};   // immediate rotates by twice the 4-bit field

  always_comb begin
    val2_o = rm_i;
    if (mem_en_i) begin
      val2_o = {{(DW-12){1'b0}}, so_i};
    end else if (imm_i) begin
      val2_o = ror32({{(DW-8){1'b0}}, so_i[7:0]}, rot_amt);
    end else begin
      case (shift_e'(so_i[6:5]))
        SH_LSL:  val2_o = rm_i << sh_amt;
        SH_LSR:  val2_o = rm_i >> sh_amt;
        SH_ASR:  val2_o = $unsigned($signed(rm_i) >>> sh_amt);
        default: val2_o = ror32(rm_i, sh_amt);
      endcase
    end
  end
endmodule

// File: rtl/exe_stage.sv
// Purpose: execute stage - ALU, NZCV status register, branch target and the EXE/MEM pipeline register.
// Ports: clk/rst (async active-low), freeze/flush, dec (exe_if.slave), flags z/c/n/v, branch_taken/addr,
//        registered wb_en_out/mem_r_out/mem_w_out/alu_res/st_val/dest_out. Build option: FWD_EN.
module exe_stage
  import exe_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          flush,
  exe_if.slave          dec,
  output logic          z,
  output logic          c,
  output logic          n,
  output logic          v,
  output logic          branch_taken,
  output logic [DW-1:0] branch_addr,
  output logic          wb_en_out,
  output logic          mem_r_out,
  output logic          mem_w_out,
  output logic [DW-1:0] alu_res,
  output logic [DW-1:0] st_val,
  output logic [RW-1:0] dest_out
);
  logic [DW-1:0] op_rn, op_rm, val2, res;
  logic [DW:0]   sum;
  logic          upd_nz, upd_cv, ovf;
  logic [3:0]    nzcv_q, nzcv_d;
  exmem_t        exmem_q, exmem_d;

  // Operand selection
`ifdef FWD_EN
  always_comb begin
    case (dec.sel_src1)
      2'b01:   op_rn = dec.mem_fwd_val;
      2'b10:   op_rn = dec.wb_fwd_val;
      default: op_rn = dec.val_rn;
    endcase
    case (dec.sel_src2)
      2'b01:   op_rm = dec.mem_fwd_val;
      2'b10:   op_rm = dec.wb_fwd_val;
      default: op_rm = dec.val_rm;
    endcase
  end
`else
  assign op_rn = dec.val_rn;
  assign op_rm = dec.val_rm;
`endif

  val2_gen u_val2 (
    .mem_en_i (dec.mem_r_in | dec.mem_w_in),
    .imm_i    (dec.imm),
    .so_i     (dec.shift_operand),
    .rm_i     (op_rm),
    .val2_o   (val2)
  );

  // ALU: subtraction is rn + ~val2 + 1, so sum[DW] is the ARM "no borrow" carry.
  always_comb begin
    sum    = '0;
    res    = '0;
    upd_nz = 1'b0;
    upd_cv = 1'b0;
    ovf    = 1'b0;
    case (dec.exe_cmd)
      EXE_MOV: begin res = val2;          upd_nz = 1'b1; end
      EXE_MVN: begin res = ~val2;         upd_nz = 1'b1; end
      EXE_AND: begin res = op_rn & val2;  upd_nz = 1'b1; end
      EXE_ORR: begin res = op_rn | val2;  upd_nz = 1'b1; end
      EXE_EOR: begin res = op_rn ^ val2;  upd_nz = 1'b1; end
      EXE_ADD, EXE_ADC: begin
        sum = {1'b0, op_rn} + {1'b0, val2} + {{DW{1'b0}}, (dec.exe_cmd == EXE_ADC) & nzcv_q[1]};
        res = sum[DW-1:0];
        ovf = (op_rn[DW-1] == val2[DW-1]) && (res[DW-1] != op_rn[DW-1]);
        upd_nz = 1'b1;
        upd_cv = 1'b1;
      end
      EXE_SUB, EXE_SBC: begin
        // SBC: rn - val2 - ~C == rn + ~val2 + C
        sum = {1'b0, op_rn} + {1'b0, ~val2} +
              {{DW{1'b0}}, (dec.exe_cmd == EXE_SUB) | nzcv_q[1]};
        res = sum[DW-1:0];
        ovf = (op_rn[DW-1] != val2[DW-1]) && (res[DW-1] != op_rn[DW-1]);
        upd_nz = 1'b1;
        upd_cv = 1'b1;
      end
      default: ;
    endcase
  end

  // Status register next state: {N,Z,C,V}
  always_comb begin
    nzcv_d = nzcv_q;
    if (dec.s_in && !freeze && !flush) begin
      if (upd_nz) nzcv_d[3:2] = {res[DW-1], res == '0};
      if (upd_cv) nzcv_d[1:0] = {sum[DW], ovf};
    end
  end

  // EXE/MEM next state: freeze holds, flush inserts a bubble
  always_comb begin
    exmem_d = exmem_q;
    if (!freeze) begin
      if (flush) begin
        exmem_d = '0;
      end else begin
        exmem_d.wb_en   = dec.wb_en_in;
        exmem_d.mem_r   = dec.mem_r_in;
        exmem_d.mem_w   = dec.mem_w_in;
        exmem_d.alu_res = res;
        exmem_d.st_val  = op_rm;
        exmem_d.dest    = dec.dest_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nzcv_q  <= '0;
      exmem_q <= '0;
    end else begin
      nzcv_q  <= nzcv_d;
      exmem_q <= exmem_d;
    end
  end

  assign {n, z, c, v} = nzcv_q;
  assign wb_en_out    = exmem_q.wb_en;
  assign mem_r_out    = exmem_q.mem_r;
  assign mem_w_out    = exmem_q.mem_w;
  assign alu_res      = exmem_q.alu_res;
  assign st_val       = exmem_q.st_val;
  assign dest_out     = exmem_q.dest;

  assign branch_taken = dec.b_in & ~flush;
  assign branch_addr  = dec.pc_in + {{(DW-26){dec.signed_imm[23]}}, dec.signed_imm, 2'b00};
endmodule
